// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared types and default widths for the data_sync CDC pair
//
// Holds the receiver FSM state encoding and the default bus/counter widths.
// The source-side transmitter imports the same widths.

package data_sync_pkg;

    localparam int DEFAULT_BUS_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        ACK_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/data_sync_rx.sv
// rtl/data_sync_rx.sv - destination-side receiver of a 4-phase req/ack multi-bit CDC transfer
//
// Captures the quasi-static source bus when the synchronized request is seen,
// offers the word to a consumer over a valid/ready handshake, and returns a
// level acknowledge to the source once the word has been accepted.
//
// Optional feature macro: DATA_SYNC_RX_PARITY_EN (adds even-parity check on capture).
//
// Ports:
//   CLK         destination clock, rising edge
//   RST         synchronous active-high reset
//   REQ_SYNC    source request, already synchronized to CLK
//   UNSYNC_BUS  source data bus, stable while source request is high
//   BUS_READY   consumer accepts SYNC_BUS this cycle
//   SYNC_BUS    captured word (registered)
//   BUS_VALID   SYNC_BUS holds an unaccepted word
//   ACK         acknowledge level to source domain (registered)
//   XFER_CNT    words accepted by the consumer, wraps
//   UNSYNC_PAR  (parity build) even parity of UNSYNC_BUS from the source
//   PAR_ERR     (parity build) one-cycle pulse when a captured word fails parity

module data_sync_rx
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_SYNC,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_READY,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 BUS_VALID,
    output logic                 ACK,
    output logic [CNT_WIDTH-1:0] XFER_CNT
`ifdef DATA_SYNC_RX_PARITY_EN
    ,
    input  logic                 UNSYNC_PAR,
    output logic                 PAR_ERR
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    state_t                 state_d;
    logic [BUS_WIDTH-1:0]   bus_d;
    logic                   valid_d;
    logic                   ack_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   par_err_d;
    logic                   par_ok;

`ifdef DATA_SYNC_RX_PARITY_EN
    // Even parity: the source sets UNSYNC_PAR so the total count of ones is even.
    assign par_ok = ((^UNSYNC_BUS) == UNSYNC_PAR);
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bus_d     = SYNC_BUS;
        valid_d   = BUS_VALID;
        ack_d     = ACK;
        cnt_d     = XFER_CNT;
        par_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (REQ_SYNC) begin
                    if (par_ok) begin
                        bus_d   = UNSYNC_BUS;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        // Corrupt word is dropped but still acknowledged so the
                        // source handshake completes and the link does not stall.
                        par_err_d = 1'b1;
                        ack_d     = 1'b1;
                        state_d   = ACK_WAIT;
                    end
                end
            end
            HOLD: begin
                // REQ_SYNC is deliberately not looked at here.
                if (BUS_READY) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = XFER_CNT + CNT_ONE;
                    state_d = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (!REQ_SYNC) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            SYNC_BUS  <= '0;
            BUS_VALID <= 1'b0;
            ACK       <= 1'b0;
            XFER_CNT  <= '0;
        end else begin
            state_q   <= state_d;
            SYNC_BUS  <= bus_d;
            BUS_VALID <= valid_d;
            ACK       <= ack_d;
            XFER_CNT  <= cnt_d;
        end
    end

`ifdef DATA_SYNC_RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            PAR_ERR <= 1'b0;
        end else begin
            PAR_ERR <= par_err_d;
        end
    end
`else
    logic unused_par_err;
    assign unused_par_err = par_err_d;
`endif

endmodule

// File: tb/tb_data_sync_rx.sv
// tb/tb_data_sync_rx.sv - self-checking bench for data_sync_rx

module tb_data_sync_rx;

    localparam int BW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_SYNC;
    logic [BW-1:0] UNSYNC_BUS;
    logic          BUS_READY;
    logic [BW-1:0] SYNC_BUS;
    logic          BUS_VALID;
    logic          ACK;
    logic [CW-1:0] XFER_CNT;
`ifdef DATA_SYNC_RX_PARITY_EN
    logic          UNSYNC_PAR;
    logic          PAR_ERR;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: number of words handed to the consumer since reset and
    // the most recently captured word.
    int          acc_cnt   = 0;
    logic [BW-1:0] last_word = '0;

    always #5 CLK = ~CLK;

    data_sync_rx #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_SYNC   (REQ_SYNC),
        .UNSYNC_BUS (UNSYNC_BUS),
        .BUS_READY  (BUS_READY),
        .SYNC_BUS   (SYNC_BUS),
        .BUS_VALID  (BUS_VALID),
        .ACK        (ACK),
        .XFER_CNT   (XFER_CNT)
`ifdef DATA_SYNC_RX_PARITY_EN
        ,
        .UNSYNC_PAR (UNSYNC_PAR),
        .PAR_ERR    (PAR_ERR)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [BW-1:0] e_bus,
                             input logic e_valid, input logic e_ack, input logic e_perr);
        chk({tag, "_bus"},   32'(SYNC_BUS),  32'(e_bus));
        chk({tag, "_valid"}, 32'(BUS_VALID), 32'(e_valid));
        chk({tag, "_ack"},   32'(ACK),       32'(e_ack));
        chk({tag, "_cnt"},   32'(XFER_CNT),  32'(acc_cnt % (1 << CW)));
`ifdef DATA_SYNC_RX_PARITY_EN
        chk({tag, "_perr"},  32'(PAR_ERR),   32'(e_perr));
`else
        if (e_perr) chk({tag, "_perr_unexpected"}, 32'(e_perr), 32'(0));
`endif
    endtask

    task automatic set_bus(input logic [BW-1:0] d);
        UNSYNC_BUS = d;
`ifdef DATA_SYNC_RX_PARITY_EN
        UNSYNC_PAR = ^d;
`endif
    endtask

    // One complete 4-phase transfer seen from the receiver side.
    task automatic xfer(input string tag, input logic [BW-1:0] data,
                        input int stall, input int hold);
        set_bus(data);
        REQ_SYNC  = 1'b1;
        BUS_READY = (stall == 0);
        step();
        last_word = data;
        check_all({tag, "_cap"}, last_word, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < stall; i++) begin
            set_bus(BW'($urandom));
            REQ_SYNC = 1'($urandom);
            step();
            check_all({tag, "_stall"}, last_word, 1'b1, 1'b0, 1'b0);
        end
        REQ_SYNC  = 1'b1;
        BUS_READY = 1'b1;
        if (stall != 0) step();
        else step();
        acc_cnt++;
        check_all({tag, "_acc"}, last_word, 1'b0, 1'b1, 1'b0);
        BUS_READY = 1'($urandom);
        for (int i = 0; i < hold; i++) begin
            set_bus(BW'($urandom));
            step();
            check_all({tag, "_hold"}, last_word, 1'b0, 1'b1, 1'b0);
        end
        REQ_SYNC = 1'b0;
        step();
        check_all({tag, "_drop"}, last_word, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RST       = 1'b1;
        REQ_SYNC  = 1'b1;
        BUS_READY = 1'b0;
        set_bus(8'hA5);

        // Reset held with an active request: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("reset", '0, 1'b0, 1'b0, 1'b0);
        end
        RST      = 1'b0;
        REQ_SYNC = 1'b0;
        step();
        check_all("idle", '0, 1'b0, 1'b0, 1'b0);

        // Ready held high: valid lasts exactly one cycle.
        xfer("single", 8'h3C, 0, 0);
        chk("single_cnt1", 32'(XFER_CNT), 32'd1);

        // Consumer stall of 10 cycles with the source bus changing underneath.
        xfer("stall", 8'hF0, 10, 2);

        // Ready while nothing is valid is ignored.
        BUS_READY = 1'b1;
        REQ_SYNC  = 1'b0;
        step();
        check_all("ready_idle", last_word, 1'b0, 1'b0, 1'b0);

        // Counter wrap with a 4-bit counter.
        RST = 1'b1;
        step();
        RST = 1'b0;
        acc_cnt   = 0;
        last_word = '0;
        for (int i = 1; i <= 17; i++) begin
            xfer("wrap", BW'(i * 7), i % 3, i % 2);
            if (i == 16) chk("wrap_at16", 32'(XFER_CNT), 32'd0);
            if (i == 17) chk("wrap_at17", 32'(XFER_CNT), 32'd1);
        end

        // Reset while a word is held, request still high afterwards.
        set_bus(8'h5A);
        REQ_SYNC  = 1'b1;
        BUS_READY = 1'b0;
        step();
        last_word = 8'h5A;
        check_all("mid_hold_cap", last_word, 1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        step();
        acc_cnt = 0;
        check_all("mid_hold_rst", '0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        set_bus(8'h77);
        step();
        last_word = 8'h77;
        check_all("mid_hold_recap", last_word, 1'b1, 1'b0, 1'b0);

        // Accept, then reset while waiting for the request to drop.
        BUS_READY = 1'b1;
        step();
        acc_cnt++;
        check_all("mid_ack_acc", last_word, 1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        step();
        acc_cnt = 0;
        check_all("mid_ack_rst", '0, 1'b0, 1'b0, 1'b0);
        RST       = 1'b0;
        BUS_READY = 1'b0;
        set_bus(8'h99);
        step();
        last_word = 8'h99;
        check_all("mid_ack_recap", last_word, 1'b1, 1'b0, 1'b0);
        BUS_READY = 1'b1;
        step();
        acc_cnt++;
        check_all("mid_ack_acc2", last_word, 1'b0, 1'b1, 1'b0);
        REQ_SYNC = 1'b0;
        step();
        check_all("mid_ack_drop", last_word, 1'b0, 1'b0, 1'b0);

`ifdef DATA_SYNC_RX_PARITY_EN
        // Bad parity: word dropped, acknowledged, one-cycle error pulse.
        UNSYNC_BUS = 8'h01;
        UNSYNC_PAR = 1'b0;
        REQ_SYNC   = 1'b1;
        BUS_READY  = 1'b1;
        step();
        check_all("par_bad", last_word, 1'b0, 1'b1, 1'b1);
        step();
        check_all("par_bad_hold", last_word, 1'b0, 1'b1, 1'b0);
        REQ_SYNC = 1'b0;
        step();
        check_all("par_bad_drop", last_word, 1'b0, 1'b0, 1'b0);
        xfer("par_good", 8'h01, 0, 0);
`endif

        // Randomized transfers against the model.
        for (int i = 0; i < 40; i++) begin
            xfer("rand", BW'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_sync_rx.md
# data_sync_rx

Destination-side receiver for a 4-phase request/acknowledge multi-bit CDC transfer. It consumes the 1-bit synchronized request produced by a multi-flop synchronizer and captures the quasi-static source bus. It then presents the captured word to a destination-domain consumer with a valid/ready handshake, and returns an acknowledge level to the source domain. It sits directly downstream of the request synchronizer. ACK is re-synchronized into the source domain by a second synchronizer instance outside this block.

## Interface
- BUS_WIDTH, 8, width of transferred data word
- CNT_WIDTH, 16, width of completed-transfer counter
- CLK  input  1  destination-domain clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- REQ_SYNC  input  1  source request, already synchronized to CLK
- UNSYNC_BUS  input  BUS_WIDTH  source data bus, unsynchronized; stable while source REQ is high
- BUS_READY  input  1  consumer accepts SYNC_BUS this cycle
- SYNC_BUS  output  BUS_WIDTH  captured word, registered
- BUS_VALID  output  1  SYNC_BUS holds an unaccepted word
- ACK  output  1  acknowledge level to source domain, registered
- XFER_CNT  output  CNT_WIDTH  count of words accepted by consumer, registered

## Operation
- FSM states: IDLE, HOLD, ACK_WAIT.
- IDLE: ACK=0, BUS_VALID=0. When REQ_SYNC=1 is sampled, UNSYNC_BUS is loaded into SYNC_BUS, BUS_VALID is set to 1, and the FSM goes to HOLD. UNSYNC_BUS is sampled only on this edge; it is never sampled in any other state.
- HOLD: SYNC_BUS and BUS_VALID are held. When BUS_READY=1 is sampled, BUS_VALID clears, ACK sets to 1, XFER_CNT increments, and the FSM goes to ACK_WAIT. With BUS_READY=0 the block stalls indefinitely, and REQ_SYNC is ignored.
- ACK_WAIT: ACK=1. When REQ_SYNC=0 is sampled, ACK clears and the FSM goes to IDLE. While REQ_SYNC=1 the block holds.
- SYNC_BUS retains its last captured value after acceptance; it updates only on capture.
- XFER_CNT wraps from all-ones to 0, with no saturation or flag.
- BUS_READY while BUS_VALID=0 is ignored.
- Reset, including reset mid-transfer, forces IDLE and overrides every other event on the same edge. Reset values: SYNC_BUS=0, BUS_VALID=0, ACK=0, XFER_CNT=0. A source left with REQ high re-triggers a fresh capture on the first post-reset edge that samples REQ_SYNC=1.
- REQ_SYNC toggling inside HOLD is a source protocol violation. It has no effect; the assertion bench flags it.

## Timing
- REQ_SYNC first sampled high at edge n: SYNC_BUS and BUS_VALID=1 are visible after edge n.
- BUS_READY sampled high at edge m (m ≥ n+1): BUS_VALID=0, ACK=1, and XFER_CNT+1 are visible after edge m.
- REQ_SYNC sampled low at edge k (k ≥ m+1): ACK=0 after edge k. The earliest next capture is edge k+1.
- Minimum receiver-side cycle is 3 CLK edges per word, excluding the synchronizer latency in both directions.
- Back-to-back acceptance: a consumer holding BUS_READY=1 accepts on the first edge after BUS_VALID rises.

## Configuration
- DATA_SYNC_RX_PARITY_EN: when defined, the block adds two ports:
  - input UNSYNC_PAR (1 bit): even parity of UNSYNC_BUS, source-generated.
  - output PAR_ERR (1 bit, registered, reset 0).
- Behaviour in IDLE with the macro defined, when REQ_SYNC=1 is sampled:
  - If the parity of UNSYNC_BUS and UNSYNC_PAR mismatch, PAR_ERR pulses high for one cycle, SYNC_BUS is not updated, BUS_VALID stays 0, XFER_CNT is unchanged, ACK sets to 1, and the FSM goes directly to ACK_WAIT. The word is dropped.
  - On a match, behaviour is identical to the build without the macro.
- When not defined, the ports are absent and there is no parity logic.

## Structure
- Package data_sync_pkg holds:
  - the state enum typedef (IDLE, HOLD, ACK_WAIT);
  - the default-width localparams shared with the source-side transmitter.
- No sub-module inside this block; the FSM, capture register and counter are inline.
- The request synchronizer (NUM_STAGES=2, BUS_WIDTH=1) is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold RST=1 with REQ_SYNC=1 and UNSYNC_BUS=8'hA5 for 3 cycles -> SYNC_BUS=0, BUS_VALID=0, ACK=0, XFER_CNT=0 throughout.
- Single transfer: UNSYNC_BUS=8'h3C, raise REQ_SYNC, BUS_READY=1 -> SYNC_BUS=8'h3C with BUS_VALID=1 for exactly 1 cycle, then ACK=1; drop REQ_SYNC -> ACK=0 one cycle later; XFER_CNT=1.
- Consumer stall: BUS_READY=0 for 10 cycles after capture of 8'hF0, then change UNSYNC_BUS to 8'h0F -> SYNC_BUS stays 8'hF0 and BUS_VALID stays 1, ACK=0; BUS_READY=1 -> ACK rises the next cycle.
- Counter wrap: CNT_WIDTH=4, 17 complete transfers -> XFER_CNT reads 0 after transfer 16 and 1 after transfer 17.
- Reset mid-transfer: assert RST while in HOLD, and again while in ACK_WAIT -> all outputs return to 0 on that edge; REQ_SYNC still high after reset -> a new capture occurs on the next edge.
- Parity (macro defined): UNSYNC_BUS=8'h01, UNSYNC_PAR=0 -> PAR_ERR=1 for 1 cycle, BUS_VALID never rises, ACK=1, XFER_CNT unchanged; with UNSYNC_PAR=1 -> normal transfer.
